video_tx_csr_shadow: RTL and testbench
======================================

// Module: video_tx_csr_shadow
// PURPOSE
//  Multi-channel video TX control/status register block on the USI slave bus; drives display timing, reset/DMA control and per-channel frame-buffer windows.
//  Timing and frame-buffer registers are double-buffered: writes land in shadow copies, and the active outputs change only on a frame-start pulse after a commit.
//  Captures per-channel scene-fade completion as sticky W1C flags and raises a maskable interrupt. Sits between the USI bus and the VideoTx timing/DMA/scene logic.
// PARAMETERS
//  pBlockAdrsMap 8 ; width of block-select field        pAdrsMap 'h04 ; block id matched in iSUsiAdrs
//  pBusAdrsBit 32 ; bus address width (>= pBlockAdrsMap+pCsrAdrsWidth)   pCsrAdrsWidth 16 ; in-block offset width
//  pChNum 2 ; frame-buffer/scene channels (1..8)       pMemAdrsWidth 19 ; frame-buffer address/length width
//  pHdisplay 480, pHfront 8, pHback 43, pHpulse 30, pVdisplay 272, pVfront 12, pVback 4, pVpulse 10 ; reset timing
//  pHWidth 11, pVWidth 11 ; timing field widths (every timing field uses these)
// PORTS
//  iSysClk  in 1 ; system clock
//  iSysRst  in 1 ; asynchronous, active-low reset
//  iSUsiWd in 32 ; write data      iSUsiAdrs in pBusAdrsBit ; R/W address      iSUsiWCke in 1 ; write strobe
//  oSUsiRd out 32 ; read data      oSUsiREd out 1 ; read valid
//  iFrameStart in 1 ; one-cycle pulse at start of vertical blanking (commit point)
//  iSceneAlphaMax in pChNum ; per-channel fade-in done level     iSceneAlphaMin in pChNum ; per-channel fade-out done level
//  oHdisplay/oHfront/oHpulse/oHback out pHWidth ; active H timing   oVdisplay/oVfront/oVpulse/oVback out pVWidth ; active V timing
//  oHSyncStart/oHSyncEnd/oHSyncMax out pHWidth+1 ; derived H   oVSyncStart/oVSyncEnd/oVSyncMax out pVWidth+1 ; derived V
//  oVtbSystemRst out 1 ; oVtbVideoRst out 1 ; oDisplayRst out 1 ; oDmaEn out 1 ; oBlDutyRatio out 8
//  oFbufAdrs out pChNum*pMemAdrsWidth ; active start adrs, ch n at [n*W +: W]   oFbufLen out pChNum*pMemAdrsWidth ; active length
//  oIrq out 1 ; level interrupt = |(status & mask)
// BEHAVIOUR
//  Map (offset = iSUsiAdrs[pCsrAdrsWidth-1:0]; hit = block field == pAdrsMap):
//   0x0000/04/08/0C display/back/front/pulse {V[31:16],H[15:0]} shadow; 0x0010 ctrl {DmaEn,DispRst,VidRst,SysRst}[3:0], immediate
//   0x0014 BlDutyRatio[7:0], immediate; 0x0018 commit: write bit0=1 sets pending, read bit0=pending
//   0x001C status W1C: [n]=AlphaMax ch n, [8+n]=AlphaMin ch n; 0x0020 irq mask, same layout
//   0x0100+8n FbufAdrs ch n shadow; 0x0104+8n FbufLen ch n shadow; 0x3000/04/08 derived {V,H} Start/End/Max, RO
//  Reset (async, iSysRst=0): shadow=active=parameter timing; FbufAdrs n=n*Hd*Vd, FbufLen n=Hd*Vd; SysRst=VidRst=DispRst=1;
//   DmaEn=0; Duty=0; pending=0; status=0; mask=0; oIrq=0; oSUsiRd=0; oSUsiREd=0; derived = parameter formulas.
//  Writes: take effect the cycle after iSUsiWCke & hit; unused data bits ignored; writes to RO/unmapped offsets ignored.
//  Commit: on iFrameStart with pending=1, all shadow->active in one cycle and pending clears. No iFrameStart -> no change.
//   Commit write and iFrameStart in the same cycle: copy uses pre-write pending; pending then ends 1 (new request kept).
//   Shadow write in the same cycle as a commit: the pre-write shadow value is copied; the new value waits for the next commit.
//  Derived (one cycle after active changes): Start=D+F; End=D+F+P-1; Max=D+F+P+B-1; zero-extended to width+1, wraps mod 2^(width+1).
//  Status: rising edge of iSceneAlpha* (registered prior sample) sets its bit; set wins over a same-cycle W1C clear.
//  Read: oSUsiRd and oSUsiREd registered, 1-cycle latency; oSUsiREd=1 only on hit (every cycle hit holds);
//   unmapped/out-of-range channel offsets read 0; ch >= pChNum reads 0.
//  oIrq is registered: one cycle after status/mask change.
// CONFIGURATION
//  VIDEO_TX_CSR_TIMING_RW_EN defined: 0x0000-0x000C writable/shadowed as above.
//  Undefined: timing fixed at parameters, writes ignored, reads return parameter values; derived regs are constants; FB shadowing unaffected.
// TESTING
//  1 Reset release -> read 0x3008 after 1 cycle = {V 297, H 560}; 0x0104 = 130560; oDisplayRst=1, oIrq=0.
//  2 (RW_EN) write 0x0000=0x0258_0320, no commit, 3 iFrameStart -> oHdisplay stays 480; write 0x0018=1, iFrameStart -> 800/600 next cycle, pending reads 0.
//  3 Write 0x0100=0x1000 with 0x0018=1 in same cycle as iFrameStart -> oFbufAdrs ch0 unchanged; next iFrameStart -> 0x1000.
//  4 mask=0x001, pulse iSceneAlphaMax[0] -> status bit0=1, oIrq=1; W1C 0x1 coinciding with a new edge -> bit stays 1; W1C alone -> oIrq=0.
//  5 Read 0x0040 (unmapped) -> 0 with oSUsiREd=1; read of other block id -> oSUsiREd=0.
//  6 Assert iSysRst mid-commit (pending=1) -> all outputs return to reset values immediately, pending=0.

Source files
------------

// File: rtl/video_tx_csr_shadow.sv
// video_tx_csr_shadow: USI-bus CSR block with double-buffered display timing and frame-buffer windows.
// Optional feature macro: VIDEO_TX_CSR_TIMING_RW_EN (timing registers writable and shadowed; otherwise fixed).
module video_tx_csr_shadow #(
    parameter int pBlockAdrsMap = 8,
    parameter int pAdrsMap      = 'h04,
    parameter int pBusAdrsBit   = 32,
    parameter int pCsrAdrsWidth = 16,
    parameter int pChNum        = 2,
    parameter int pMemAdrsWidth = 19,
    parameter int pHdisplay     = 480,
    parameter int pHfront       = 8,
    parameter int pHback        = 43,
    parameter int pHpulse       = 30,
    parameter int pVdisplay     = 272,
    parameter int pVfront       = 12,
    parameter int pVback        = 4,
    parameter int pVpulse       = 10,
    parameter int pHWidth       = 11,
    parameter int pVWidth       = 11
) (
    input  logic                            iSysClk,
    input  logic                            iSysRst,
    input  logic [31:0]                     iSUsiWd,
    input  logic [pBusAdrsBit-1:0]          iSUsiAdrs,
    input  logic                            iSUsiWCke,
    output logic [31:0]                     oSUsiRd,
    output logic                            oSUsiREd,
    input  logic                            iFrameStart,
    input  logic [pChNum-1:0]               iSceneAlphaMax,
    input  logic [pChNum-1:0]               iSceneAlphaMin,
    output logic [pHWidth-1:0]              oHdisplay,
    output logic [pHWidth-1:0]              oHfront,
    output logic [pHWidth-1:0]              oHpulse,
    output logic [pHWidth-1:0]              oHback,
    output logic [pVWidth-1:0]              oVdisplay,
    output logic [pVWidth-1:0]              oVfront,
    output logic [pVWidth-1:0]              oVpulse,
    output logic [pVWidth-1:0]              oVback,
    output logic [pHWidth:0]                oHSyncStart,
    output logic [pHWidth:0]                oHSyncEnd,
    output logic [pHWidth:0]                oHSyncMax,
    output logic [pVWidth:0]                oVSyncStart,
    output logic [pVWidth:0]                oVSyncEnd,
    output logic [pVWidth:0]                oVSyncMax,
    output logic                            oVtbSystemRst,
    output logic                            oVtbVideoRst,
    output logic                            oDisplayRst,
    output logic                            oDmaEn,
    output logic [7:0]                      oBlDutyRatio,
    output logic [pChNum*pMemAdrsWidth-1:0] oFbufAdrs,
    output logic [pChNum*pMemAdrsWidth-1:0] oFbufLen,
    output logic                            oIrq
);
    localparam int cHW = pHWidth + 1;
    localparam int cVW = pVWidth + 1;
    localparam int cFb = pHdisplay * pVdisplay;
    // Timing arrays are indexed by register offset: 0 display, 1 back, 2 front, 3 pulse
    localparam logic [3:0][pHWidth-1:0] cHRst = {pHWidth'(pHpulse), pHWidth'(pHfront), pHWidth'(pHback), pHWidth'(pHdisplay)};
    localparam logic [3:0][pVWidth-1:0] cVRst = {pVWidth'(pVpulse), pVWidth'(pVfront), pVWidth'(pVback), pVWidth'(pVdisplay)};
    localparam logic [cHW-1:0] cHStart = cHW'(pHdisplay + pHfront);
    localparam logic [cHW-1:0] cHEnd   = cHW'(pHdisplay + pHfront + pHpulse - 1);
    localparam logic [cHW-1:0] cHMax   = cHW'(pHdisplay + pHfront + pHpulse + pHback - 1);
    localparam logic [cVW-1:0] cVStart = cVW'(pVdisplay + pVfront);
    localparam logic [cVW-1:0] cVEnd   = cVW'(pVdisplay + pVfront + pVpulse - 1);
    localparam logic [cVW-1:0] cVMax   = cVW'(pVdisplay + pVfront + pVpulse + pVback - 1);
    localparam logic [pCsrAdrsWidth-1:0] aCtrl = 'h10, aDuty = 'h14, aCommit = 'h18, aStat = 'h1C, aMask = 'h20;
    localparam logic [pCsrAdrsWidth-1:0] aStart = 'h3000, aEnd = 'h3004, aMax = 'h3008;

    function automatic logic [pChNum*pMemAdrsWidth-1:0] fbInit(input int step, input int base);
        fbInit = '0;
        for (int n = 0; n < pChNum; n++) fbInit[n*pMemAdrsWidth +: pMemAdrsWidth] = pMemAdrsWidth'(base + n * step);
    endfunction

    localparam logic [pChNum*pMemAdrsWidth-1:0] cAdrsRst = fbInit(cFb, 0);
    localparam logic [pChNum*pMemAdrsWidth-1:0] cLenRst  = fbInit(0, cFb);

    logic                            hit, wr, doCommit, timHit, fbHit, pending, unusedBits;
    logic [pCsrAdrsWidth-1:0]        ofs;
    logic [2:0]                      fbCh;
    logic [31:0]                     rdMux;
    logic [3:0]                      ctrl;
    logic [3:0][pHWidth-1:0]         shH, actH;
    logic [3:0][pVWidth-1:0]         shV, actV;
    logic [pChNum*pMemAdrsWidth-1:0] shAdrs, shLen;
    logic [pChNum-1:0]               maxQ, minQ, stMax, stMin, mkMax, mkMin;
    logic [cHW-1:0]                  hStart, hEnd, hMax;
    logic [cVW-1:0]                  vStart, vEnd, vMax;

    assign ofs        = iSUsiAdrs[pCsrAdrsWidth-1:0];
    assign hit        = iSUsiAdrs[pCsrAdrsWidth +: pBlockAdrsMap] == pBlockAdrsMap'(pAdrsMap);
    assign wr         = iSUsiWCke & hit;
    assign doCommit   = iFrameStart & pending;
    assign timHit     = ofs[pCsrAdrsWidth-1:4] == '0 && ofs[1:0] == 2'b00;
    assign fbCh       = ofs[5:3];
    assign fbHit      = ofs[pCsrAdrsWidth-1:6] == (pCsrAdrsWidth-6)'(4) && ofs[1:0] == 2'b00 && int'(fbCh) < pChNum;
    assign unusedBits = ^{iSUsiWd, iSUsiAdrs};

    assign {oHpulse, oHfront, oHback, oHdisplay} = actH;
    assign {oVpulse, oVfront, oVback, oVdisplay} = actV;
    assign {oDmaEn, oDisplayRst, oVtbVideoRst, oVtbSystemRst} = ctrl;

`ifdef VIDEO_TX_CSR_TIMING_RW_EN
    // Timing shadow writes; shadows move to active only on a pending frame-start commit
    always_ff @(posedge iSysClk or negedge iSysRst)
        if (!iSysRst) begin
            shH  <= cHRst;
            shV  <= cVRst;
            actH <= cHRst;
            actV <= cVRst;
        end else begin
            if (wr && timHit) begin
                shH[ofs[3:2]] <= iSUsiWd[pHWidth-1:0];
                shV[ofs[3:2]] <= iSUsiWd[16 +: pVWidth];
            end
            if (doCommit) begin
                actH <= shH;
                actV <= shV;
            end
        end
`else
    assign shH  = cHRst;
    assign shV  = cVRst;
    assign actH = cHRst;
    assign actV = cVRst;
`endif

    // Sync points derived from the active timing, wrapping at width+1 bits
    always_comb begin
        hStart = cHW'(actH[0]) + cHW'(actH[2]);
        hEnd   = hStart + cHW'(actH[3]) - cHW'(1);
        hMax   = hEnd + cHW'(actH[1]);
        vStart = cVW'(actV[0]) + cVW'(actV[2]);
        vEnd   = vStart + cVW'(actV[3]) - cVW'(1);
        vMax   = vEnd + cVW'(actV[1]);
    end

    // Register derived timing one cycle behind the active values
    always_ff @(posedge iSysClk or negedge iSysRst)
        if (!iSysRst) begin
            {oHSyncStart, oHSyncEnd, oHSyncMax} <= {cHStart, cHEnd, cHMax};
            {oVSyncStart, oVSyncEnd, oVSyncMax} <= {cVStart, cVEnd, cVMax};
        end else begin
            {oHSyncStart, oHSyncEnd, oHSyncMax} <= {hStart, hEnd, hMax};
            {oVSyncStart, oVSyncEnd, oVSyncMax} <= {vStart, vEnd, vMax};
        end

    // Immediate control/duty registers and the commit request flag
    always_ff @(posedge iSysClk or negedge iSysRst)
        if (!iSysRst) begin
            ctrl         <= 4'b0111;
            oBlDutyRatio <= '0;
            pending      <= 1'b0;
        end else begin
            if (wr && ofs == aCtrl) ctrl <= iSUsiWd[3:0];
            if (wr && ofs == aDuty) oBlDutyRatio <= iSUsiWd[7:0];
            pending <= (wr && ofs == aCommit && iSUsiWd[0]) || (pending && !iFrameStart);
        end

    // Frame-buffer window shadows and their committed active copies
    always_ff @(posedge iSysClk or negedge iSysRst)
        if (!iSysRst) begin
            shAdrs    <= cAdrsRst;
            shLen     <= cLenRst;
            oFbufAdrs <= cAdrsRst;
            oFbufLen  <= cLenRst;
        end else begin
            if (wr && fbHit && ofs[2]) shLen[int'(fbCh)*pMemAdrsWidth +: pMemAdrsWidth] <= iSUsiWd[pMemAdrsWidth-1:0];
            if (wr && fbHit && !ofs[2]) shAdrs[int'(fbCh)*pMemAdrsWidth +: pMemAdrsWidth] <= iSUsiWd[pMemAdrsWidth-1:0];
            if (doCommit) begin
                oFbufAdrs <= shAdrs;
                oFbufLen  <= shLen;
            end
        end

    // Sticky fade-done flags: a rising edge sets, W1C clears, set wins
    always_ff @(posedge iSysClk or negedge iSysRst)
        if (!iSysRst) begin
            {maxQ, minQ, stMax, stMin, mkMax, mkMin} <= '0;
        end else begin
            maxQ  <= iSceneAlphaMax;
            minQ  <= iSceneAlphaMin;
            stMax <= (stMax & ~((wr && ofs == aStat) ? iSUsiWd[pChNum-1:0] : '0)) | (iSceneAlphaMax & ~maxQ);
            stMin <= (stMin & ~((wr && ofs == aStat) ? iSUsiWd[8 +: pChNum] : '0)) | (iSceneAlphaMin & ~minQ);
            if (wr && ofs == aMask) {mkMin, mkMax} <= {iSUsiWd[8 +: pChNum], iSUsiWd[pChNum-1:0]};
        end

    // Registered level interrupt from masked status
    always_ff @(posedge iSysClk or negedge iSysRst)
        if (!iSysRst) oIrq <= 1'b0;
        else oIrq <= |{stMax & mkMax, stMin & mkMin};

    // Read-data select by offset; unmapped offsets read zero
    always_comb begin
        rdMux = '0;
        if (timHit) rdMux = (32'(shV[ofs[3:2]]) << 16) | 32'(shH[ofs[3:2]]);
        else if (ofs == aCtrl) rdMux = 32'(ctrl);
        else if (ofs == aDuty) rdMux = 32'(oBlDutyRatio);
        else if (ofs == aCommit) rdMux = 32'(pending);
        else if (ofs == aStat) rdMux = (32'(stMin) << 8) | 32'(stMax);
        else if (ofs == aMask) rdMux = (32'(mkMin) << 8) | 32'(mkMax);
        else if (fbHit) rdMux = 32'(ofs[2] ? shLen[int'(fbCh)*pMemAdrsWidth +: pMemAdrsWidth] : shAdrs[int'(fbCh)*pMemAdrsWidth +: pMemAdrsWidth]);
        else if (ofs == aStart) rdMux = (32'(oVSyncStart) << 16) | 32'(oHSyncStart);
        else if (ofs == aEnd) rdMux = (32'(oVSyncEnd) << 16) | 32'(oHSyncEnd);
        else if (ofs == aMax) rdMux = (32'(oVSyncMax) << 16) | 32'(oHSyncMax);
    end

    // Registered read port: valid on every cycle the block is addressed
    always_ff @(posedge iSysClk or negedge iSysRst)
        if (!iSysRst) begin
            oSUsiRd  <= '0;
            oSUsiREd <= 1'b0;
        end else begin
            oSUsiRd  <= hit ? rdMux : '0;
            oSUsiREd <= hit;
        end
endmodule

// File: tb/tb_video_tx_csr_shadow.sv
// tb_video_tx_csr_shadow: scoreboard bench for the video TX CSR shadow block
module tb_video_tx_csr_shadow;
    logic        iSysClk = 1'b0, iSysRst = 1'b0, iSUsiWCke = 1'b0, iFrameStart = 1'b0;
    logic [31:0] iSUsiWd = '0, iSUsiAdrs = '0, oSUsiRd;
    logic        oSUsiREd, oIrq, oVtbSystemRst, oVtbVideoRst, oDisplayRst, oDmaEn;
    logic [1:0]  iSceneAlphaMax = '0, iSceneAlphaMin = '0;
    logic [10:0] oHdisplay, oHfront, oHpulse, oHback, oVdisplay, oVfront, oVpulse, oVback;
    logic [11:0] oHSyncStart, oHSyncEnd, oHSyncMax, oVSyncStart, oVSyncEnd, oVSyncMax;
    logic [7:0]  oBlDutyRatio;
    logic [37:0] oFbufAdrs, oFbufLen;

    int          checks = 0, failures = 0;
    logic [31:0] expQ[$];
    logic [31:0] e;

`ifdef VIDEO_TX_CSR_TIMING_RW_EN
    localparam logic [31:0] eRd0 = 32'h0258_0320, eMax = 32'h0271_0370, eStart = 32'h0264_0328;
    localparam logic [10:0] eHd = 11'd800, eVd = 11'd600;
    localparam logic [11:0] eHs = 12'd808;
`else
    localparam logic [31:0] eRd0 = 32'h0110_01E0, eMax = 32'h0129_0230, eStart = 32'h011C_01E8;
    localparam logic [10:0] eHd = 11'd480, eVd = 11'd272;
    localparam logic [11:0] eHs = 12'd488;
`endif

    video_tx_csr_shadow dut (
        .iSysClk(iSysClk), .iSysRst(iSysRst), .iSUsiWd(iSUsiWd), .iSUsiAdrs(iSUsiAdrs), .iSUsiWCke(iSUsiWCke),
        .oSUsiRd(oSUsiRd), .oSUsiREd(oSUsiREd), .iFrameStart(iFrameStart),
        .iSceneAlphaMax(iSceneAlphaMax), .iSceneAlphaMin(iSceneAlphaMin),
        .oHdisplay(oHdisplay), .oHfront(oHfront), .oHpulse(oHpulse), .oHback(oHback),
        .oVdisplay(oVdisplay), .oVfront(oVfront), .oVpulse(oVpulse), .oVback(oVback),
        .oHSyncStart(oHSyncStart), .oHSyncEnd(oHSyncEnd), .oHSyncMax(oHSyncMax),
        .oVSyncStart(oVSyncStart), .oVSyncEnd(oVSyncEnd), .oVSyncMax(oVSyncMax),
        .oVtbSystemRst(oVtbSystemRst), .oVtbVideoRst(oVtbVideoRst), .oDisplayRst(oDisplayRst), .oDmaEn(oDmaEn),
        .oBlDutyRatio(oBlDutyRatio), .oFbufAdrs(oFbufAdrs), .oFbufLen(oFbufLen), .oIrq(oIrq)
    );

    always #5 iSysClk = ~iSysClk;

    task automatic tick();
        @(posedge iSysClk);
        #1;
    endtask

    task automatic rd(input logic [15:0] o, input logic [31:0] x);
        iSUsiAdrs = 32'h0004_0000 | 32'(o);
        iSUsiWCke = 1'b0;
        expQ.push_back(x);
        tick();
    endtask

    task automatic wr(input logic [15:0] o, input logic [31:0] d);
        iSUsiAdrs = 32'h0004_0000 | 32'(o);
        iSUsiWd   = d;
        iSUsiWCke = 1'b1;
        tick();
        iSUsiWCke = 1'b0;
    endtask

    task automatic pulse();
        iFrameStart = 1'b1;
        tick();
        iFrameStart = 1'b0;
    endtask

    task automatic test_reset();
        iSysRst = 1'b0;
        repeat (2) tick();
        checks++; if ({oDisplayRst, oVtbVideoRst, oVtbSystemRst, oDmaEn, oIrq, oSUsiREd} !== 6'b111000) begin failures++; $display("FAIL rst_flags got=%b exp=111000", {oDisplayRst, oVtbVideoRst, oVtbSystemRst, oDmaEn, oIrq, oSUsiREd}); end
        checks++; if ({oHSyncMax, oVSyncMax} !== {12'd560, 12'd297}) begin failures++; $display("FAIL rst_derived got=%0d/%0d exp=560/297", oHSyncMax, oVSyncMax); end
        checks++; if (oFbufAdrs[37:19] !== 19'd130560 || oFbufLen[18:0] !== 19'd130560) begin failures++; $display("FAIL rst_fbuf got=%0d/%0d exp=130560", oFbufAdrs[37:19], oFbufLen[18:0]); end
        iSysRst = 1'b1;
        rd(16'h3008, 32'h0129_0230); e = expQ.pop_front(); checks++;
        if (!oSUsiREd || oSUsiRd !== e) begin failures++; $display("FAIL rst_max got=%h red=%b exp=%h", oSUsiRd, oSUsiREd, e); end
        rd(16'h0104, 32'd130560); e = expQ.pop_front(); checks++;
        if (!oSUsiREd || oSUsiRd !== e) begin failures++; $display("FAIL rst_len0 got=%h red=%b exp=%h", oSUsiRd, oSUsiREd, e); end
        rd(16'h0108, 32'd130560); e = expQ.pop_front(); checks++;
        if (!oSUsiREd || oSUsiRd !== e) begin failures++; $display("FAIL rst_adrs1 got=%h red=%b exp=%h", oSUsiRd, oSUsiREd, e); end
        rd(16'h0010, 32'h7); e = expQ.pop_front(); checks++;
        if (!oSUsiREd || oSUsiRd !== e) begin failures++; $display("FAIL rst_ctrl got=%h red=%b exp=%h", oSUsiRd, oSUsiREd, e); end
    endtask

    task automatic test_timing();
        wr(16'h0000, 32'h0258_0320);
        repeat (3) pulse();
        checks++; if (oHdisplay !== 11'd480) begin failures++; $display("FAIL tim_nocommit got=%0d exp=480", oHdisplay); end
        rd(16'h0000, eRd0); e = expQ.pop_front(); checks++;
        if (!oSUsiREd || oSUsiRd !== e) begin failures++; $display("FAIL tim_shadow got=%h red=%b exp=%h", oSUsiRd, oSUsiREd, e); end
        wr(16'h0018, 32'h1);
        pulse();
        checks++; if ({oHdisplay, oVdisplay} !== {eHd, eVd}) begin failures++; $display("FAIL tim_commit got=%0d/%0d exp=%0d/%0d", oHdisplay, oVdisplay, eHd, eVd); end
        tick();
        checks++; if (oHSyncStart !== eHs) begin failures++; $display("FAIL tim_hstart got=%0d exp=%0d", oHSyncStart, eHs); end
        rd(16'h0018, 32'h0); e = expQ.pop_front(); checks++;
        if (!oSUsiREd || oSUsiRd !== e) begin failures++; $display("FAIL tim_pending got=%h red=%b exp=%h", oSUsiRd, oSUsiREd, e); end
        rd(16'h3008, eMax); e = expQ.pop_front(); checks++;
        if (!oSUsiREd || oSUsiRd !== e) begin failures++; $display("FAIL tim_max got=%h red=%b exp=%h", oSUsiRd, oSUsiREd, e); end
    endtask

    task automatic test_fbuf();
        wr(16'h0100, 32'h1000);
        iFrameStart = 1'b1; wr(16'h0018, 32'h1); iFrameStart = 1'b0;
        checks++; if (oFbufAdrs[18:0] !== 19'h0) begin failures++; $display("FAIL fb_same_cycle got=%h exp=0", oFbufAdrs[18:0]); end
        rd(16'h0018, 32'h1); e = expQ.pop_front(); checks++;
        if (!oSUsiREd || oSUsiRd !== e) begin failures++; $display("FAIL fb_pending_kept got=%h red=%b exp=%h", oSUsiRd, oSUsiREd, e); end
        pulse();
        checks++; if (oFbufAdrs[18:0] !== 19'h1000) begin failures++; $display("FAIL fb_commit got=%h exp=1000", oFbufAdrs[18:0]); end
        wr(16'h010C, 32'h3333);
        wr(16'h0018, 32'h1);
        iFrameStart = 1'b1; wr(16'h010C, 32'h4444); iFrameStart = 1'b0;
        checks++; if (oFbufLen[37:19] !== 19'h3333) begin failures++; $display("FAIL fb_prewrite got=%h exp=3333", oFbufLen[37:19]); end
        rd(16'h010C, 32'h4444); e = expQ.pop_front(); checks++;
        if (!oSUsiREd || oSUsiRd !== e) begin failures++; $display("FAIL fb_shadow got=%h red=%b exp=%h", oSUsiRd, oSUsiREd, e); end
        rd(16'h0018, 32'h0); e = expQ.pop_front(); checks++;
        if (!oSUsiREd || oSUsiRd !== e) begin failures++; $display("FAIL fb_pending_clr got=%h red=%b exp=%h", oSUsiRd, oSUsiREd, e); end
        wr(16'h0018, 32'h1);
        iFrameStart = 1'b1; wr(16'h0018, 32'h1); iFrameStart = 1'b0;
        checks++; if (oFbufLen[37:19] !== 19'h4444) begin failures++; $display("FAIL fb_commit2 got=%h exp=4444", oFbufLen[37:19]); end
        rd(16'h0018, 32'h1); e = expQ.pop_front(); checks++;
        if (!oSUsiREd || oSUsiRd !== e) begin failures++; $display("FAIL fb_rerequest got=%h red=%b exp=%h", oSUsiRd, oSUsiREd, e); end
        rd(16'h0110, 32'h0); e = expQ.pop_front(); checks++;
        if (!oSUsiREd || oSUsiRd !== e) begin failures++; $display("FAIL fb_ch2 got=%h red=%b exp=%h", oSUsiRd, oSUsiREd, e); end
    endtask

    task automatic test_status();
        wr(16'h0020, 32'h001);
        iSceneAlphaMax = 2'b01; tick();
        rd(16'h001C, 32'h1); e = expQ.pop_front(); checks++;
        if (!oSUsiREd || oSUsiRd !== e) begin failures++; $display("FAIL st_set got=%h red=%b exp=%h", oSUsiRd, oSUsiREd, e); end
        checks++; if (oIrq !== 1'b1) begin failures++; $display("FAIL st_irq_on got=%b exp=1", oIrq); end
        iSceneAlphaMax = 2'b00; tick();
        iSceneAlphaMax = 2'b01; wr(16'h001C, 32'h1);
        rd(16'h001C, 32'h1); e = expQ.pop_front(); checks++;
        if (!oSUsiREd || oSUsiRd !== e) begin failures++; $display("FAIL st_set_wins got=%h red=%b exp=%h", oSUsiRd, oSUsiREd, e); end
        wr(16'h001C, 32'h1); tick();
        checks++; if (oIrq !== 1'b0) begin failures++; $display("FAIL st_irq_off got=%b exp=0", oIrq); end
        iSceneAlphaMin = 2'b10; tick();
        rd(16'h001C, 32'h200); e = expQ.pop_front(); checks++;
        if (!oSUsiREd || oSUsiRd !== e) begin failures++; $display("FAIL st_min1 got=%h red=%b exp=%h", oSUsiRd, oSUsiREd, e); end
        checks++; if (oIrq !== 1'b0) begin failures++; $display("FAIL st_masked got=%b exp=0", oIrq); end
        wr(16'h0020, 32'h200); tick();
        checks++; if (oIrq !== 1'b1) begin failures++; $display("FAIL st_unmask got=%b exp=1", oIrq); end
        wr(16'h001C, 32'h200); tick();
        checks++; if (oIrq !== 1'b0) begin failures++; $display("FAIL st_min_clr got=%b exp=0", oIrq); end
    endtask

    task automatic test_ctrl();
        wr(16'h0010, 32'h8);
        checks++; if ({oDmaEn, oDisplayRst, oVtbVideoRst, oVtbSystemRst} !== 4'b1000) begin failures++; $display("FAIL ctrl_wr got=%b exp=1000", {oDmaEn, oDisplayRst, oVtbVideoRst, oVtbSystemRst}); end
        wr(16'h0014, 32'h1AB);
        checks++; if (oBlDutyRatio !== 8'hAB) begin failures++; $display("FAIL duty got=%h exp=ab", oBlDutyRatio); end
        iSUsiAdrs = 32'h0005_0010; iSUsiWd = 32'h7; iSUsiWCke = 1'b1; tick(); iSUsiWCke = 1'b0;
        rd(16'h0010, 32'h8); e = expQ.pop_front(); checks++;
        if (!oSUsiREd || oSUsiRd !== e) begin failures++; $display("FAIL ctrl_other_blk got=%h red=%b exp=%h", oSUsiRd, oSUsiREd, e); end
        wr(16'h3000, 32'hFFFF_FFFF);
        rd(16'h3000, eStart); e = expQ.pop_front(); checks++;
        if (!oSUsiREd || oSUsiRd !== e) begin failures++; $display("FAIL ro_start got=%h red=%b exp=%h", oSUsiRd, oSUsiREd, e); end
    endtask

    task automatic test_read();
        rd(16'h0040, 32'h0); e = expQ.pop_front(); checks++;
        if (!oSUsiREd || oSUsiRd !== e) begin failures++; $display("FAIL rd_unmapped got=%h red=%b exp=%h", oSUsiRd, oSUsiREd, e); end
        iSUsiAdrs = 32'h0005_0000; tick();
        checks++; if (oSUsiREd !== 1'b0 || oSUsiRd !== 32'h0) begin failures++; $display("FAIL rd_other_blk got=%h red=%b exp=0/0", oSUsiRd, oSUsiREd); end
    endtask

    task automatic test_reset_mid();
        iSUsiAdrs = 32'h0004_0018; tick();
        #2 iSysRst = 1'b0;
        #1;
        checks++; if ({oDmaEn, oDisplayRst, oVtbVideoRst, oVtbSystemRst, oBlDutyRatio} !== {4'b0111, 8'h00}) begin failures++; $display("FAIL rmid_ctrl got=%b exp=011100000000", {oDmaEn, oDisplayRst, oVtbVideoRst, oVtbSystemRst, oBlDutyRatio}); end
        checks++; if (oSUsiREd !== 1'b0 || oIrq !== 1'b0) begin failures++; $display("FAIL rmid_rd got=%b/%b exp=0/0", oSUsiREd, oIrq); end
        checks++; if (oFbufLen[37:19] !== 19'd130560 || oFbufAdrs[18:0] !== 19'h0) begin failures++; $display("FAIL rmid_fbuf got=%h/%h exp=1fe00/0", oFbufLen[37:19], oFbufAdrs[18:0]); end
        checks++; if (oHdisplay !== 11'd480 || oHSyncMax !== 12'd560) begin failures++; $display("FAIL rmid_tim got=%0d/%0d exp=480/560", oHdisplay, oHSyncMax); end
        tick();
        iSysRst = 1'b1;
        rd(16'h0018, 32'h0); e = expQ.pop_front(); checks++;
        if (!oSUsiREd || oSUsiRd !== e) begin failures++; $display("FAIL rmid_pending got=%h red=%b exp=%h", oSUsiRd, oSUsiREd, e); end
        rd(16'h010C, 32'd130560); e = expQ.pop_front(); checks++;
        if (!oSUsiREd || oSUsiRd !== e) begin failures++; $display("FAIL rmid_shadow got=%h red=%b exp=%h", oSUsiRd, oSUsiREd, e); end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_fbuf();
        test_status();
        test_ctrl();
        test_read();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
